// File: rtl/fp_issue_queue_pkg.sv
// Shared definitions for the FP-add issue queue: register address type,
// queue entry layout and issue FSM states.
package fp_issue_queue_pkg;
   typedef logic [4:0] RegAddr;
   typedef logic Signal;

   localparam Signal ENABLE  = 1'b1;
   localparam Signal DISABLE = 1'b0;

   typedef struct packed {
      RegAddr fs;
      RegAddr ft;
      RegAddr fd;
   } FpIssueEntry;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      ACK,
      BUSY
   } FpIssueState;
endpackage

// File: rtl/fp_issue_fifo.sv
// Count-based circular FIFO of decoded FP-add instructions.
// A push in a flush cycle is dropped; a full FIFO accepts a push when popping.
module fp_issue_fifo
   import fp_issue_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  FpIssueEntry din,
   output FpIssueEntry dout,
   output logic        full,
   output logic        empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   FpIssueEntry      mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && !flush && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is pure data and carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/fp_issue_queue.sv
// Issues queued FP-add ops to the FPU wrapper one at a time, waiting for the
// wrapper's working flag to fall before the next issue so RAW on fd is safe.
module fp_issue_queue
   import fp_issue_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [4:0]       in_fs,
   input  logic [4:0]       in_ft,
   input  logic [4:0]       in_fd,
   output logic             in_ready,
   input  logic             flush,
   input  logic             stall_in,
   input  logic             fpu_working,
   output logic             start,
   output logic [4:0]       fs_addr,
   output logic [4:0]       ft_addr,
   output logic [4:0]       fd_addr,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] issue_cnt
);
   FpIssueState state;
   FpIssueEntry head;
   FpIssueEntry in_entry;
   logic        full;
   logic        empty;
   logic        pop;
   logic        push;
   logic        ack_wait;

   assign in_entry = '{fs: in_fs, ft: in_ft, fd: in_fd};
   assign pop      = (state == IDLE) && !empty && !fpu_working;
   assign in_ready = !full || pop;
   assign push     = in_valid && in_ready;
   assign start    = (state == ISSUE) && !stall_in;
   assign busy     = (state != IDLE) || !empty;

   fp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (in_entry),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   // Addresses only change on IDLE->ISSUE: the FPU latches fd while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ack_wait  <= DISABLE;
         err       <= DISABLE;
         issue_cnt <= '0;
         fs_addr   <= '0;
         ft_addr   <= '0;
         fd_addr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  fs_addr <= head.fs;
                  ft_addr <= head.ft;
                  fd_addr <= head.fd;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (!stall_in) begin
                  ack_wait  <= DISABLE;
                  issue_cnt <= issue_cnt + 1'b1;
                  state     <= ACK;
               end
            end
            ACK: begin
               if (fpu_working) begin
                  state <= BUSY;
               end else if (ack_wait) begin
                  err   <= ENABLE;
                  state <= IDLE;
               end else begin
                  ack_wait <= ENABLE;
               end
            end
            BUSY: begin
               if (!fpu_working) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_issue_queue.sv
// Directed bench for fp_issue_queue with a small FPU model that raises
// working one cycle after start and holds it for four cycles.
module tb_fp_issue_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  in_fs = '0;
   logic [4:0]  in_ft = '0;
   logic [4:0]  in_fd = '0;
   logic        in_ready;
   logic        flush = 1'b0;
   logic        stall_in = 1'b0;
   logic        fpu_working;
   logic        start;
   logic [4:0]  fs_addr;
   logic [4:0]  ft_addr;
   logic [4:0]  fd_addr;
   logic        busy;
   logic        err;
   logic [15:0] issue_cnt;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   wcnt;
   logic fpu_en = 1'b1;
   logic fpu_hold = 1'b0;

   fp_issue_queue #(.DEPTH(4), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_fs       (in_fs),
      .in_ft       (in_ft),
      .in_fd       (in_fd),
      .in_ready    (in_ready),
      .flush       (flush),
      .stall_in    (stall_in),
      .fpu_working (fpu_working),
      .start       (start),
      .fs_addr     (fs_addr),
      .ft_addr     (ft_addr),
      .fd_addr     (fd_addr),
      .busy        (busy),
      .err         (err),
      .issue_cnt   (issue_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) wcnt <= 0;
      else if (fpu_en && start) wcnt <= 4;
      else if (wcnt != 0) wcnt <= wcnt - 1;
   end
   assign fpu_working = fpu_hold || (wcnt != 0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [4:0] fs, input logic [4:0] ft, input logic [4:0] fd);
      in_valid = 1'b1;
      in_fs = fs;
      in_ft = ft;
      in_fd = fd;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start got %b exp 0", start); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
      n_cmp++; if (issue_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", issue_cnt); end
      n_cmp++; if ({fs_addr, ft_addr, fd_addr} !== 15'd0) begin n_bad++; $display("FAIL reset_addrs got %0d/%0d/%0d exp 0/0/0", fs_addr, ft_addr, fd_addr); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int   nst;
      logic moved;
      push_op(5'd1, 5'd2, 5'd3);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_queued got %b exp 1", busy); end
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL single_start_early got %b exp 0", start); end
      tick();
      n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL single_start got %b exp 1", start); end
      n_cmp++; if ({fs_addr, ft_addr, fd_addr} !== {5'd1, 5'd2, 5'd3}) begin n_bad++; $display("FAIL single_addrs got %0d/%0d/%0d exp 1/2/3", fs_addr, ft_addr, fd_addr); end
      tick();
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL single_start_once got %b exp 0", start); end
      n_cmp++; if (issue_cnt !== 16'd1) begin n_bad++; $display("FAIL single_cnt got %0d exp 1", issue_cnt); end
      nst = 0;
      moved = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (start) nst++;
         if ({fs_addr, ft_addr, fd_addr} !== {5'd1, 5'd2, 5'd3}) moved = 1'b1;
         tick();
      end
      n_cmp++; if (nst != 0) begin n_bad++; $display("FAIL single_extra_start got %0d exp 0", nst); end
      n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL single_addr_hold got changed exp held"); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      int   s1;
      int   s2;
      int   nst;
      logic fd_bad;
      push_op(5'd1, 5'd2, 5'd3);
      push_op(5'd3, 5'd4, 5'd5);
      s1 = -1;
      s2 = -1;
      nst = 0;
      fd_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (start) begin
            if (nst == 0) s1 = i;
            else if (nst == 1) s2 = i;
            nst++;
            if (nst == 2 && fd_addr !== 5'd5) fd_bad = 1'b1;
         end
         if (nst < 2 && fd_addr !== 5'd3) fd_bad = 1'b1;
         tick();
      end
      n_cmp++; if (s1 != 0) begin n_bad++; $display("FAIL raw_first_start got %0d exp 0", s1); end
      n_cmp++; if (s2 != 7) begin n_bad++; $display("FAIL raw_second_start got %0d exp 7", s2); end
      n_cmp++; if (fd_bad !== 1'b0) begin n_bad++; $display("FAIL raw_fd_hold got changed exp 3 then 5"); end
      n_cmp++; if (issue_cnt !== 16'd3) begin n_bad++; $display("FAIL raw_cnt got %0d exp 3", issue_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL raw_idle got %b exp 0", busy); end
   endtask

   task automatic test_full();
      logic [4:0] got [5];
      logic [4:0] exp_fs [5];
      int         nst;
      exp_fs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
      fpu_hold = 1'b1;
      for (int k = 1; k <= 4; k++) push_op(5'(k), 5'(k + 8), 5'(k + 16));
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
      in_valid = 1'b1; in_fs = 5'd5; in_ft = 5'd13; in_fd = 5'd21;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_reject got %b exp 0", in_ready); end
      tick();
      fpu_hold = 1'b0;
      in_fs = 5'd6; in_ft = 5'd14; in_fd = 5'd22;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_push_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_still_full got %b exp 0", in_ready); end
      n_cmp++; if (fs_addr !== 5'd1) begin n_bad++; $display("FAIL full_head got %0d exp 1", fs_addr); end
      nst = 0;
      for (int i = 0; i < 50; i++) begin
         if (start) begin
            if (nst < 5) got[nst] = fs_addr;
            nst++;
         end
         tick();
      end
      n_cmp++; if (nst != 5) begin n_bad++; $display("FAIL full_issue_count got %0d exp 5", nst); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (got[k] !== exp_fs[k]) begin n_bad++; $display("FAIL full_order[%0d] got %0d exp %0d", k, got[k], exp_fs[k]); end
      end
      n_cmp++; if (issue_cnt !== 16'd8) begin n_bad++; $display("FAIL full_cnt got %0d exp 8", issue_cnt); end
   endtask

   task automatic test_stall();
      push_op(5'd9, 5'd10, 5'd11);
      stall_in = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL stall_start[%0d] got %b exp 0", k, start); end
         tick();
      end
      n_cmp++; if (issue_cnt !== 16'd8) begin n_bad++; $display("FAIL stall_cnt_held got %0d exp 8", issue_cnt); end
      stall_in = 1'b0;
      #1;
      n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL stall_release got %b exp 1", start); end
      tick();
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL stall_pulse_once got %b exp 0", start); end
      n_cmp++; if (issue_cnt !== 16'd9) begin n_bad++; $display("FAIL stall_cnt got %0d exp 9", issue_cnt); end
      repeat (10) tick();
      n_cmp++; if (issue_cnt !== 16'd9) begin n_bad++; $display("FAIL stall_cnt_final got %0d exp 9", issue_cnt); end
   endtask

   task automatic test_no_ack();
      fpu_en = 1'b0;
      push_op(5'd12, 5'd13, 5'd14);
      push_op(5'd15, 5'd16, 5'd17);
      n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL noack_start got %b exp 1", start); end
      tick();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL noack_err_c1 got %b exp 0", err); end
      tick();
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL noack_err_c2 got %b exp 0", err); end
      tick();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL noack_err_set got %b exp 1", err); end
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL noack_idle_start got %b exp 0", start); end
      fpu_en = 1'b1;
      tick();
      n_cmp++; if (start !== 1'b1) begin n_bad++; $display("FAIL noack_next_start got %b exp 1", start); end
      n_cmp++; if (fs_addr !== 5'd15) begin n_bad++; $display("FAIL noack_next_fs got %0d exp 15", fs_addr); end
      repeat (10) tick();
      n_cmp++; if (issue_cnt !== 16'd11) begin n_bad++; $display("FAIL noack_cnt got %0d exp 11", issue_cnt); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL noack_err_sticky got %b exp 1", err); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL noack_idle got %b exp 0", busy); end
   endtask

   task automatic test_flush_reset();
      int nst;
      push_op(5'd1, 5'd3, 5'd5);
      push_op(5'd7, 5'd8, 5'd9);
      push_op(5'd10, 5'd11, 5'd12);
      push_op(5'd13, 5'd14, 5'd15);
      flush = 1'b1;
      in_valid = 1'b1; in_fs = 5'd20; in_ft = 5'd21; in_fd = 5'd22;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_inflight_busy got %b exp 1", busy); end
      n_cmp++; if (fd_addr !== 5'd5) begin n_bad++; $display("FAIL flush_inflight_fd got %0d exp 5", fd_addr); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
      nst = 0;
      for (int i = 0; i < 10; i++) begin
         if (start) nst++;
         tick();
      end
      n_cmp++; if (nst != 0) begin n_bad++; $display("FAIL flush_no_issue got %0d exp 0", nst); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle got %b exp 0", busy); end
      n_cmp++; if (issue_cnt !== 16'd12) begin n_bad++; $display("FAIL flush_cnt got %0d exp 12", issue_cnt); end
      push_op(5'd2, 5'd4, 5'd6);
      repeat (3) tick();
      push_op(5'd3, 5'd3, 5'd3);
      n_cmp++; if (fd_addr !== 5'd6) begin n_bad++; $display("FAIL rst_pre_fd got %0d exp 6", fd_addr); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL rst_async_start got %b exp 0", start); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy got %b exp 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_async_err got %b exp 0", err); end
      n_cmp++; if (issue_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_async_cnt got %0d exp 0", issue_cnt); end
      n_cmp++; if ({fs_addr, ft_addr, fd_addr} !== 15'd0) begin n_bad++; $display("FAIL rst_async_addrs got %0d/%0d/%0d exp 0/0/0", fs_addr, ft_addr, fd_addr); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_stall();
      test_no_ack();
      test_flush_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
